seq_packet_job_merger: RTL and testbench
========================================

Name: seq_packet_job_merger

Overview:
- Downstream of the NUM_JOB_PE job_match_pe_cluster instances; consumes their seq_packet streams.
- Jobs are dispatched round-robin to job PEs 0,1,…,NUM_JOB_PE-1, then wrap. This block restores original job order by draining one cluster until a packet carrying eoj is accepted, then moving to the next cluster.
- Output is a single in-order seq_packet stream through a 2-entry output buffer, plus job/protocol status, feeding the sequence encoder.

Parameters:
- NUM_JOB_PE, 4, number of upstream clusters (power of two, ≥2)
- NUM_JOB_PE_LOG2, 2, log2(NUM_JOB_PE)
- P, `SEQ_PACKET_SIZE, lanes per packet
- LLW / MLW / OFW, `SEQ_LL_BITS / `SEQ_ML_BITS / `SEQ_OFFSET_BITS, lane field widths

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- in_valid  in  NUM_JOB_PE  per-cluster packet valid
- in_ready  out  NUM_JOB_PE  per-cluster packet ready
- in_strb  in  NUM_JOB_PE*P  lane strobes, cluster j at [j*P+:P]
- in_ll  in  NUM_JOB_PE*P*LLW  literal lengths
- in_ml  in  NUM_JOB_PE*P*MLW  match lengths
- in_offset  in  NUM_JOB_PE*P*OFW  offsets
- in_overlap  in  NUM_JOB_PE*P*MLW  overlap lengths
- in_eoj  in  NUM_JOB_PE*P  end-of-job per lane
- in_delim  in  NUM_JOB_PE*P  delimiter per lane
- out_valid  out  1  merged packet valid
- out_ready  in  1  downstream ready
- out_strb, out_ll, out_ml, out_offset, out_overlap, out_eoj, out_delim  out  P, P*LLW, P*MLW, P*OFW, P*MLW, P, P  merged packet fields
- out_job_pe_idx  out  NUM_JOB_PE_LOG2  source cluster of the packet
- job_done_count  out  32  number of eoj packets accepted (wraps)
- protocol_err  out  1  sticky protocol violation flag

Behaviour:
- Reset: cur_ptr=0; buffer count=0; out_valid=0; all out_* data=0; in_ready=0; job_done_count=0; protocol_err=0. Reset mid-operation discards buffered packets; no partial output.
- Selection: only cluster cur_ptr may be accepted. in_ready[j] = (j==cur_ptr) && (count<2). The term depends only on registers, never on out_ready or in_valid.
- Accept: in_valid[cur_ptr] && in_ready[cur_ptr]. The packet is written into the buffer with source index cur_ptr.
- Buffer: 2-entry FIFO, registered output, latency 1 cycle from accept to out_valid.
  - Push and pop in the same cycle leave count unchanged.
  - Full-rate throughput (1 packet/cycle) is sustained while out_ready stays high.
  - Output fields hold stable while out_valid && !out_ready.
- Packet with in_strb == 0: accepted and dropped; not buffered.
- Job advance: when an accepted packet has any in_eoj lane set:
  - cur_ptr <= (cur_ptr+1) mod NUM_JOB_PE on the same clock edge;
  - job_done_count increments.
  - The next cycle may accept from the new cluster.
- Delim: carried through unchanged; it does not affect pointer movement.
- Protocol checks, evaluated on accept. Each sets protocol_err (sticky until reset); the packet is still forwarded unchanged.
  - strb is not contiguous from lane 0 (strb not of the form 2^k-1).
  - An eoj lane is not the highest strobed lane.
  - eoj or delim is set on an unstrobed lane.
- in_valid on a non-current cluster is ignored; that cluster stays stalled with in_ready=0, with no error.
- Wrap: cur_ptr and job_done_count roll over naturally.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all inputs 0 → out_valid=0, in_ready=4'b0000 during reset, 4'b0001 after; job_done_count=0.
- In-order merge: PE1 presents a 1-packet job (strb=4'b0011, eoj=4'b0010) from cycle 0. PE0 presents 2 packets (strb=4'b1111, eoj=0; then strb=4'b0001, eoj=4'b0001) from cycle 3. Expected: PE1 stalls; output order is PE0 pkt0, PE0 pkt1, PE1 pkt, with out_job_pe_idx 0,0,1; job_done_count=2.
- Backpressure: out_ready=0 for 5 cycles while PE0 streams → exactly 2 packets accepted, in_ready[0]=0 thereafter. On release, packets emerge in order with no loss or duplication, and data stays stable while stalled.
- Throughput: out_ready=1, PE0 sends 8 back-to-back packets → 8 outputs on 8 consecutive cycles, first output 1 cycle after first accept.
- Wrap: 5 single-packet eoj jobs from PE0,1,2,3,0 → cur_ptr returns to 1, job_done_count=5, out_job_pe_idx sequence 0,1,2,3,0.
- Protocol error: PE0 packet strb=4'b0101 → protocol_err=1 next cycle and stays 1; packet still output. A separate packet strb=4'b0111, eoj=4'b0010 also sets protocol_err. rst clears it.

Source files
------------

// File: rtl/seq_packet_job_merger.sv
// Merges per-cluster seq_packet streams back into original job order by draining
// one cluster until an eoj packet is accepted, then moving to the next cluster.
module seq_packet_job_merger #(
  parameter int NUM_JOB_PE      = 4,
  parameter int NUM_JOB_PE_LOG2 = 2,
  parameter int P               = 4,
  parameter int LLW             = 8,
  parameter int MLW             = 8,
  parameter int OFW             = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_JOB_PE-1:0]         in_valid,
  output logic [NUM_JOB_PE-1:0]         in_ready,
  input  logic [NUM_JOB_PE*P-1:0]       in_strb,
  input  logic [NUM_JOB_PE*P*LLW-1:0]   in_ll,
  input  logic [NUM_JOB_PE*P*MLW-1:0]   in_ml,
  input  logic [NUM_JOB_PE*P*OFW-1:0]   in_offset,
  input  logic [NUM_JOB_PE*P*MLW-1:0]   in_overlap,
  input  logic [NUM_JOB_PE*P-1:0]       in_eoj,
  input  logic [NUM_JOB_PE*P-1:0]       in_delim,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [P-1:0]                  out_strb,
  output logic [P*LLW-1:0]              out_ll,
  output logic [P*MLW-1:0]              out_ml,
  output logic [P*OFW-1:0]              out_offset,
  output logic [P*MLW-1:0]              out_overlap,
  output logic [P-1:0]                  out_eoj,
  output logic [P-1:0]                  out_delim,
  output logic [NUM_JOB_PE_LOG2-1:0]    out_job_pe_idx,
  output logic [31:0]                   job_done_count,
  output logic                          protocol_err
);

  localparam int PKT_W = NUM_JOB_PE_LOG2 + 3*P + P*LLW + 2*P*MLW + P*OFW;

  logic [NUM_JOB_PE_LOG2-1:0] cur_ptr;
  logic                       run;
  logic [1:0]                 count;
  logic                       wr_ptr;
  logic                       rd_ptr;
  logic [PKT_W-1:0]           mem [2];

  logic                       sel_valid;
  logic [P-1:0]               sel_strb;
  logic [P-1:0]               sel_eoj;
  logic [P-1:0]               sel_delim;
  logic [P*LLW-1:0]           sel_ll;
  logic [P*MLW-1:0]           sel_ml;
  logic [P*OFW-1:0]           sel_offset;
  logic [P*MLW-1:0]           sel_overlap;
  logic [P-1:0]               strb_msb;

  logic accept;
  logic push;
  logic pop;
  logic has_eoj;
  logic bad_pkt;

  // Ready is a function of registers only, so it never forms a path from
  // out_ready or in_valid; run keeps it low while and right after reset.
  always_comb begin
    in_ready    = '0;
    sel_valid   = 1'b0;
    sel_strb    = '0;
    sel_eoj     = '0;
    sel_delim   = '0;
    sel_ll      = '0;
    sel_ml      = '0;
    sel_offset  = '0;
    sel_overlap = '0;
    for (int j = 0; j < NUM_JOB_PE; j++) begin
      if (cur_ptr == NUM_JOB_PE_LOG2'(j)) begin
        in_ready[j] = run && (count != 2'd2);
        sel_valid   = in_valid[j];
        sel_strb    = in_strb[j*P +: P];
        sel_eoj     = in_eoj[j*P +: P];
        sel_delim   = in_delim[j*P +: P];
        sel_ll      = in_ll[j*P*LLW +: P*LLW];
        sel_ml      = in_ml[j*P*MLW +: P*MLW];
        sel_offset  = in_offset[j*P*OFW +: P*OFW];
        sel_overlap = in_overlap[j*P*MLW +: P*MLW];
      end
    end
  end

  // One-hot of the highest strobed lane; eoj may only sit there.
  always_comb begin
    strb_msb = '0;
    for (int i = 0; i < P; i++) begin
      if (sel_strb[i]) begin
        strb_msb    = '0;
        strb_msb[i] = 1'b1;
      end
    end
  end

  assign accept  = sel_valid && run && (count != 2'd2);
  assign push    = accept && (|sel_strb);
  assign pop     = out_valid && out_ready;
  assign has_eoj = |sel_eoj;
  assign bad_pkt = ((sel_strb & (sel_strb + P'(1))) != '0) ||
                   ((sel_eoj & ~strb_msb) != '0) ||
                   (((sel_eoj | sel_delim) & ~sel_strb) != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_ptr        <= '0;
      run            <= 1'b0;
      count          <= 2'd0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      job_done_count <= '0;
      protocol_err   <= 1'b0;
      // NOTE: the two buffer slots are cleared too, so the output data reads zero out of reset.
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      run   <= 1'b1;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push) begin
        mem[wr_ptr] <= {cur_ptr, sel_strb, sel_ll, sel_ml, sel_offset,
                        sel_overlap, sel_eoj, sel_delim};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (accept && has_eoj) begin
        cur_ptr        <= cur_ptr + NUM_JOB_PE_LOG2'(1);
        job_done_count <= job_done_count + 32'd1;
      end
      if (accept && bad_pkt) protocol_err <= 1'b1;
    end
  end

  assign out_valid = (count != 2'd0);
  assign {out_job_pe_idx, out_strb, out_ll, out_ml, out_offset,
          out_overlap, out_eoj, out_delim} = mem[rd_ptr];

endmodule

// File: tb/tb_seq_packet_job_merger.sv
// Directed bench for seq_packet_job_merger: ordering, backpressure, throughput,
// pointer wrap and protocol-error flagging with hand-computed expectations.
module tb_seq_packet_job_merger;

  localparam int NPE = 4;
  localparam int P   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NPE-1:0]   in_valid = '0;
  logic [NPE-1:0]   in_ready;
  logic [NPE*P-1:0] in_strb = '0;
  logic [NPE*P*8-1:0]  in_ll = '0;
  logic [NPE*P*8-1:0]  in_ml = '0;
  logic [NPE*P*16-1:0] in_offset = '0;
  logic [NPE*P*8-1:0]  in_overlap = '0;
  logic [NPE*P-1:0] in_eoj = '0;
  logic [NPE*P-1:0] in_delim = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [P-1:0]     out_strb;
  logic [P*8-1:0]   out_ll;
  logic [P*8-1:0]   out_ml;
  logic [P*16-1:0]  out_offset;
  logic [P*8-1:0]   out_overlap;
  logic [P-1:0]     out_eoj;
  logic [P-1:0]     out_delim;
  logic [1:0]       out_job_pe_idx;
  logic [31:0]      job_done_count;
  logic             protocol_err;

  seq_packet_job_merger dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_strb(in_strb),
    .in_ll(in_ll), .in_ml(in_ml), .in_offset(in_offset), .in_overlap(in_overlap),
    .in_eoj(in_eoj), .in_delim(in_delim),
    .out_valid(out_valid), .out_ready(out_ready), .out_strb(out_strb),
    .out_ll(out_ll), .out_ml(out_ml), .out_offset(out_offset), .out_overlap(out_overlap),
    .out_eoj(out_eoj), .out_delim(out_delim), .out_job_pe_idx(out_job_pe_idx),
    .job_done_count(job_done_count), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc   = 0;

  // Output log entry: {pe_idx[17:16], strb[15:12], eoj[11:8], ll lane0[7:0]}
  logic [17:0] mon_q[$];
  int          mon_c[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_q.push_back({out_job_pe_idx, out_strb, out_eoj, out_ll[7:0]});
      mon_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int pe, input logic [3:0] strb, input logic [3:0] eoj,
                       input logic [3:0] delim, input logic [7:0] tag);
    in_valid[pe]             = 1'b1;
    in_strb[pe*P +: P]       = strb;
    in_eoj[pe*P +: P]        = eoj;
    in_delim[pe*P +: P]      = delim;
    in_ll[pe*32 +: 32]       = {4{tag}};
    in_ml[pe*32 +: 32]       = {4{~tag}};
    in_offset[pe*64 +: 64]   = {8{tag}};
    in_overlap[pe*32 +: 32]  = {4{tag ^ 8'h5a}};
  endtask

  task automatic undrive(input int pe);
    in_valid[pe]        = 1'b0;
    in_strb[pe*P +: P]  = '0;
    in_eoj[pe*P +: P]   = '0;
    in_delim[pe*P +: P] = '0;
  endtask

  task automatic wait_acc(input int pe);
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready[pe]) ok = 1;
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 64'(pe), 64'hffff);
    undrive(pe);
  endtask

  task automatic send(input int pe, input logic [3:0] strb, input logic [3:0] eoj,
                      input logic [3:0] delim, input logic [7:0] tag);
    drive(pe, strb, eoj, delim, tag);
    wait_acc(pe);
  endtask

  task automatic stream(input int n, input int max_cyc, input logic [7:0] base,
                        output int used, output int first_fire);
    logic fire;
    used = 0;
    first_fire = -1;
    if (acc < n) drive(0, 4'hf, 4'h0, 4'h0, base + 8'(acc));
    while (acc < n && used < max_cyc) begin
      @(negedge clk);
      fire = in_valid[0] && in_ready[0];
      if (fire && first_fire < 0) first_fire = cyc;
      @(posedge clk); #1;
      used++;
      if (fire) begin
        acc++;
        if (acc < n) drive(0, 4'hf, 4'h0, 4'h0, base + 8'(acc));
        else undrive(0);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int pe = 0; pe < NPE; pe++) undrive(pe);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mon_q.delete();
    mon_c.delete();
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
    #1;
  endtask

  int used;
  int ff;

  initial begin
    // Reset then idle
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(in_ready), 64'h1);
    chk("idle_out_valid", 64'(out_valid), 64'h0);
    chk("idle_jdc", 64'(job_done_count), 64'h0);
    chk("idle_perr", 64'(protocol_err), 64'h0);
    chk("idle_out_strb", 64'(out_strb), 64'h0);

    // In-order merge: PE1 waits for PE0's two-packet job
    do_reset();
    drive(1, 4'b0011, 4'b0010, 4'b0000, 8'h11);
    repeat (3) begin @(posedge clk); #1; end
    chk("merge_pe1_stall", 64'(in_ready), 64'h1);
    chk("merge_no_out", 64'(out_valid), 64'h0);
    send(0, 4'b1111, 4'b0000, 4'b0000, 8'ha0);
    send(0, 4'b0001, 4'b0001, 4'b0000, 8'ha1);
    wait_acc(1);
    drain();
    chk("merge_count", 64'(mon_q.size()), 64'd3);
    if (mon_q.size() == 3) begin
      chk("merge_idx0", 64'(mon_q[0][17:16]), 64'd0);
      chk("merge_tag0", 64'(mon_q[0][7:0]), 64'ha0);
      chk("merge_idx1", 64'(mon_q[1][17:16]), 64'd0);
      chk("merge_tag1", 64'(mon_q[1][7:0]), 64'ha1);
      chk("merge_idx2", 64'(mon_q[2][17:16]), 64'd1);
      chk("merge_tag2", 64'(mon_q[2][7:0]), 64'h11);
      chk("merge_eoj2", 64'(mon_q[2][11:8]), 64'b0010);
    end
    chk("merge_jdc", 64'(job_done_count), 64'd2);
    chk("merge_ptr", 64'(in_ready), 64'b0100);

    // Backpressure: only two packets fit while the sink stalls
    do_reset();
    out_ready = 1'b0;
    acc = 0;
    stream(4, 5, 8'hb0, used, ff);
    chk("bp_accepted", 64'(acc), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'h0);
    chk("bp_out_valid", 64'(out_valid), 64'h1);
    chk("bp_hold_ll", 64'(out_ll[7:0]), 64'hb0);
    chk("bp_hold_strb", 64'(out_strb), 64'hf);
    @(posedge clk); #1;
    chk("bp_hold_ll2", 64'(out_ll), 64'hb0b0b0b0);
    out_ready = 1'b1;
    stream(4, 20, 8'hb0, used, ff);
    chk("bp_total_acc", 64'(acc), 64'd4);
    drain();
    chk("bp_out_count", 64'(mon_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < mon_q.size(); i++)
      chk("bp_order", 64'(mon_q[i][7:0]), 64'(8'hb0 + 8'(i)));

    // Throughput: eight back-to-back packets
    do_reset();
    out_ready = 1'b1;
    acc = 0;
    stream(8, 20, 8'hc0, used, ff);
    chk("tp_cycles", 64'(used), 64'd8);
    drain();
    chk("tp_out_count", 64'(mon_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < mon_q.size(); i++) begin
      chk("tp_tag", 64'(mon_q[i][7:0]), 64'(8'hc0 + 8'(i)));
      chk("tp_cycle", 64'(mon_c[i]), 64'(ff + 1 + i));
    end

    // Wrap: five single-packet jobs across all clusters
    do_reset();
    for (int i = 0; i < 5; i++)
      send(i % NPE, 4'b0001, 4'b0001, 4'b0000, 8'hd0 + 8'(i));
    drain();
    chk("wrap_jdc", 64'(job_done_count), 64'd5);
    chk("wrap_ptr", 64'(in_ready), 64'b0010);
    chk("wrap_count", 64'(mon_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < mon_q.size(); i++)
      chk("wrap_idx", 64'(mon_q[i][17:16]), 64'(i % NPE));

    // Protocol errors
    do_reset();
    send(0, 4'b0101, 4'b0000, 4'b0000, 8'he0);
    chk("perr_gap", 64'(protocol_err), 64'h1);
    drain();
    chk("perr_sticky", 64'(protocol_err), 64'h1);
    chk("perr_fwd_count", 64'(mon_q.size()), 64'd1);
    if (mon_q.size() == 1) chk("perr_fwd_strb", 64'(mon_q[0][15:12]), 64'b0101);
    do_reset();
    chk("perr_rst_clear", 64'(protocol_err), 64'h0);
    send(0, 4'b0011, 4'b0010, 4'b0000, 8'he1);
    chk("perr_clean", 64'(protocol_err), 64'h0);
    send(1, 4'b0000, 4'b0000, 4'b0000, 8'he2);
    drain();
    chk("drop_zero_strb", 64'(mon_q.size()), 64'd1);
    chk("drop_perr", 64'(protocol_err), 64'h0);
    send(1, 4'b0011, 4'b0000, 4'b0100, 8'he3);
    chk("perr_delim", 64'(protocol_err), 64'h1);
    do_reset();
    send(0, 4'b0111, 4'b0010, 4'b0000, 8'he4);
    chk("perr_eoj_pos", 64'(protocol_err), 64'h1);
    do_reset();
    chk("perr_rst_clear2", 64'(protocol_err), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
